// File: rtl/div_unit_pkg.sv
// Shared CPU-side definitions for the divider: word width and divider state encoding.
package div_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Start/end handshake between the control unit (master) and the divider (slave).
interface div_unit_if #(
    parameter int unsigned WIDTH = div_unit_pkg::WORD_WIDTH
);
    logic             div_control;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_end;
    logic             div_zero;
    logic             busy;

    modport master (
        output div_control, dividend, divisor,
        input  hi_out, lo_out, div_end, div_zero, busy
    );

    modport slave (
        input  div_control, dividend, divisor,
        output hi_out, lo_out, div_end, div_zero, busy
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift, compare, conditional subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH-1:0] rem_sh;
    logic             fits;

    // rem < divisor <= 2^(WIDTH-1) always holds, so the shifted remainder never overflows
    always_comb begin
        rem_sh   = {rem[WIDTH-2:0], q[WIDTH-1]};
        fits     = (rem_sh >= divisor);
        rem_next = fits ? (rem_sh - divisor) : rem_sh;
        q_next   = {q[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/div_unit.sv
// Multicycle signed restoring divider; hi = remainder, lo = quotient, one-cycle div_end pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             div_end_q;
    logic             div_zero_q;
    logic             busy_q;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // |INT_MIN| negates to itself, which is the correct unsigned magnitude
    assign dvd_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .q       (quo_q),
        .divisor (dvs_q),
        .rem_next(rem_next),
        .q_next  (quo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_end_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.div_control) begin
                        rem_q    <= '0;
                        quo_q    <= dvd_abs;
                        dvs_q    <= dvs_abs;
                        sign_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r_q <= bus.dividend[WIDTH-1];
                        count_q  <= CntW'(WIDTH);
                        busy_q   <= 1'b1;
                        if (bus.divisor == '0) begin
                            // hi/lo are deliberately left holding the previous result
                            div_end_q  <= 1'b1;
                            div_zero_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    count_q <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    lo_q       <= sign_q_q ? -quo_q : quo_q;
                    hi_q       <= sign_r_q ? -rem_q : rem_q;
                    div_end_q  <= 1'b1;
                    div_zero_q <= 1'b0;
                    state_q    <= StDone;
                end
                StDone: begin
                    div_end_q  <= 1'b0;
                    div_zero_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.div_end  = div_end_q;
    assign bus.div_zero = div_zero_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against a 64-bit arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int unsigned W = WORD_WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Architectural HI/LO as the model expects them
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MIPS DIV: truncate toward zero, remainder follows dividend; zero divisor keeps HI/LO
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output logic zero);
        longint sa, sb, q, r;
        zero = (b == '0);
        if (!zero) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            q    = sa / sb;
            r    = sa % sb;
            m_lo = q[W-1:0];
            m_hi = r[W-1:0];
        end
    endtask

    // Called at #1 after a rising edge; that cycle becomes cycle 0 of the operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                          input string tag);
        logic         zero;
        int           exp_cyc;
        int           end_cnt = 0;
        int           end_cyc = -1;
        logic         busy_ok = 1'b1;
        logic         hold_ok = 1'b1;
        logic [W-1:0] old_hi  = m_hi;
        logic [W-1:0] old_lo  = m_lo;

        model(a, b, zero);
        exp_cyc = zero ? 1 : W + 2;

        bus.div_control = 1'b1;
        bus.dividend    = a;
        bus.divisor     = b;
        @(posedge clk);
        #1;
        bus.div_control = 1'b0;
        bus.dividend    = $urandom;
        bus.divisor     = $urandom;

        for (int c = 1; c <= exp_cyc + 3; c++) begin
            bus.div_control = poke && (c == 5 || c == 20);
            if (poke && (c == 5 || c == 20)) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom_range(1, 5);
            end
            @(negedge clk);
            if (bus.div_end === 1'b1) begin
                end_cnt++;
                if (end_cyc < 0) begin
                    end_cyc = c;
                    check({tag, "/div_zero"}, 64'(bus.div_zero), 64'(zero));
                    check({tag, "/lo"}, 64'(bus.lo_out), 64'(m_lo));
                    check({tag, "/hi"}, 64'(bus.hi_out), 64'(m_hi));
                end
            end
            if (bus.busy !== (c <= exp_cyc)) busy_ok = 1'b0;
            if (c < exp_cyc && (bus.hi_out !== old_hi || bus.lo_out !== old_lo)) hold_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.div_control = 1'b0;

        check({tag, "/end_count"}, 64'(end_cnt), 64'd1);
        check({tag, "/end_cycle"}, 64'(end_cyc), 64'(exp_cyc));
        check({tag, "/busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, "/hilo_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "/hi_after"}, 64'(bus.hi_out), 64'(m_hi));
        check({tag, "/lo_after"}, 64'(bus.lo_out), 64'(m_lo));
    endtask

    initial begin
        logic         no_end;
        logic [W-1:0] ra, rb;

        bus.div_control = 1'b0;
        bus.dividend    = '0;
        bus.divisor     = '0;

        #2 reset = 1'b0;
        #20;
        check("reset/hi", 64'(bus.hi_out), 64'd0);
        check("reset/lo", 64'(bus.lo_out), 64'd0);
        check("reset/div_end", 64'(bus.div_end), 64'd0);
        check("reset/div_zero", 64'(bus.div_zero), 64'd0);
        check("reset/busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'd100, 32'd7, 1'b0, "100/7");
        run_op(32'd5, 32'd0, 1'b0, "5/0");
        run_op(-32'sd100, 32'd7, 1'b0, "-100/7");
        run_op(32'd100, -32'sd7, 1'b0, "100/-7");
        run_op(-32'sd100, -32'sd7, 1'b0, "-100/-7");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "intmin/-1");
        run_op(32'h8000_0000, 32'd1, 1'b0, "intmin/1");
        run_op(32'd7, 32'h8000_0000, 1'b0, "7/intmin");
        run_op(32'd1000, -32'sd13, 1'b1, "poke");

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            if (i % 2 == 1) rb = -rb;
            run_op(ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        run_op(32'd3, 32'd0, 1'b0, "3/0");

        // Asynchronous reset in cycle 17 of a live operation
        bus.div_control = 1'b1;
        bus.dividend    = 32'd100;
        bus.divisor     = 32'd7;
        @(posedge clk);
        #1;
        bus.div_control = 1'b0;
        repeat (16) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async/hi", 64'(bus.hi_out), 64'd0);
        check("async/lo", 64'(bus.lo_out), 64'd0);
        check("async/div_end", 64'(bus.div_end), 64'd0);
        check("async/div_zero", 64'(bus.div_zero), 64'd0);
        check("async/busy", 64'(bus.busy), 64'd0);
        m_hi   = '0;
        m_lo   = '0;
        no_end = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.div_end !== 1'b0 || bus.busy !== 1'b0) no_end = 1'b0;
        end
        reset = 1'b1;
        repeat (36) begin
            @(negedge clk);
            if (bus.div_end !== 1'b0) no_end = 1'b0;
        end
        check("async/no_div_end", 64'(no_end), 64'd1);
        @(posedge clk);
        #1;
        run_op(32'd9, 32'd3, 1'b0, "9/3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
